// File: rtl/cpu_pkg.sv
// Shared CPU-side types and constants; holds the program loader's state
// encoding and default frame sync marker.
package cpu_pkg;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_LEN  = 2'd1,
    LD_DATA = 2'd2,
    LD_CHK  = 2'd3
  } loader_state_e;

  localparam logic [7:0] LOADER_SYNC = 8'hA5;

endpackage

// File: rtl/prog_loader.sv
// Framed byte-stream loader: writes SYNC/LEN/data/CHK frames into the
// instruction RAM and holds the CPU in reset until a frame checks out.
//
// Input handshake: _iRxValid is a one-cycle strobe with no back-pressure;
// every strobe carries one byte that is consumed in that same cycle, and
// strobes may arrive on back-to-back cycles.
module prog_loader
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter bit          BOOT_HOLD      = 1'b1,
  parameter logic [7:0]  SYNC_BYTE      = LOADER_SYNC
) (
  input  logic       _iClk,
  input  logic       rst,
  input  logic [7:0] _iRxData,
  input  logic       _iRxValid,
  output logic [7:0] _oInstMemAddr,
  output logic [7:0] _oInstMemWData,
  output logic       _oInstMemWrite,
  output logic       _oCpuReset,
  output logic       _oLoadDone,
  output logic       _oLoadError
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  loader_state_e    state_q, state_d;
  logic [7:0]       len_q, len_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       sum_q, sum_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic [7:0]       mem_addr_q, mem_addr_d;
  logic [7:0]       mem_wdata_q, mem_wdata_d;
  logic             mem_write_q, mem_write_d;
  logic             cpu_rst_q, cpu_rst_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [7:0]       chk_sum;

  assign chk_sum = sum_q + _iRxData;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    addr_d      = addr_q;
    sum_d       = sum_q;
    tmo_d       = tmo_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_write_d = 1'b0;
    cpu_rst_d   = cpu_rst_q;
    done_d      = 1'b0;
    err_d       = err_q;

    if (state_q == LD_IDLE) begin
      tmo_d = '0;
      if (_iRxValid && (_iRxData == SYNC_BYTE)) begin
        state_d   = LD_LEN;
        err_d     = 1'b0;
        cpu_rst_d = 1'b1;
        sum_d     = 8'd0;
        addr_d    = 8'd0;
      end
    end else if (!_iRxValid) begin
      // A byte on the expiry cycle wins: the timeout only fires on an idle cycle.
      if (tmo_q == TMO_LAST) begin
        tmo_d     = '0;
        err_d     = 1'b1;
        cpu_rst_d = 1'b1;
        state_d   = LD_IDLE;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end else begin
      tmo_d = '0;
      case (state_q)
        LD_LEN: begin
          len_d   = _iRxData;
          state_d = LD_DATA;
        end
        LD_DATA: begin
          mem_addr_d  = addr_q;
          mem_wdata_d = _iRxData;
          mem_write_d = 1'b1;
          addr_d      = addr_q + 8'd1;
          sum_d       = chk_sum;
          // LEN of 0 compares against 8'hFF, giving a full 256-byte frame.
          if (addr_q == (len_q - 8'd1)) state_d = LD_CHK;
        end
        LD_CHK: begin
          if (chk_sum == 8'd0) begin
            done_d    = 1'b1;
            cpu_rst_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
          state_d = LD_IDLE;
        end
        default: state_d = LD_IDLE;
      endcase
    end
  end

  always_ff @(posedge _iClk or posedge rst) begin
    if (rst) begin
      state_q     <= LD_IDLE;
      len_q       <= 8'd0;
      addr_q      <= 8'd0;
      sum_q       <= 8'd0;
      tmo_q       <= '0;
      mem_addr_q  <= 8'd0;
      mem_wdata_q <= 8'd0;
      mem_write_q <= 1'b0;
      cpu_rst_q   <= BOOT_HOLD;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      addr_q      <= addr_d;
      sum_q       <= sum_d;
      tmo_q       <= tmo_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_write_q <= mem_write_d;
      cpu_rst_q   <= cpu_rst_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign _oInstMemAddr  = mem_addr_q;
  assign _oInstMemWData = mem_wdata_q;
  assign _oInstMemWrite = mem_write_q;
  assign _oCpuReset     = cpu_rst_q;
  assign _oLoadDone     = done_q;
  assign _oLoadError    = err_q;

endmodule
